multicycle_ctrl: RTL and testbench

Multicycle control FSM that sequences the RV32I datapath (PC, instruction register, register file, ALU, unified memory port) of the single-core processor.
- Decodes the latched opcode and drives per-state datapath controls.
- Runs a request/ready handshake with memory, with a watchdog timeout.
- Counts retired instructions.
- Sits in top_level between the instruction register/branch comparator and the datapath muxes and enables.

---
 rtl/rv_ctrl_pkg.sv | 55 +++++
 rtl/rv_opcode_class.sv | 30 +++
 rtl/multicycle_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        ClsRtype,
        ClsIalu,
        ClsLoad,
        ClsStore,
        ClsBranch,
        ClsJal,
        ClsJalr,
        ClsLui,
        ClsAuipc,
        ClsSystem,
        ClsIllegal
    } opclass_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_TARGET = 2'd1;
    localparam logic [1:0] PC_HOLD   = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] ALUB_RS2  = 2'd0;
    localparam logic [1:0] ALUB_IMM  = 2'd1;
    localparam logic [1:0] ALUB_FOUR = 2'd2;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_CMP   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

endpackage

// File: rtl/rv_opcode_class.sv
// Combinational opcode classifier: maps the 7-bit major opcode to an
// instruction class and flags anything outside the supported set.
module rv_opcode_class
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output opclass_t   opclass,
    output logic       illegal
);

    always_comb begin
        opclass = ClsIllegal;
        case (opcode)
            OP_RTYPE:  opclass = ClsRtype;
            OP_IALU:   opclass = ClsIalu;
            OP_LOAD:   opclass = ClsLoad;
            OP_STORE:  opclass = ClsStore;
            OP_BRANCH: opclass = ClsBranch;
            OP_JAL:    opclass = ClsJal;
            OP_JALR:   opclass = ClsJalr;
            OP_LUI:    opclass = ClsLui;
            OP_AUIPC:  opclass = ClsAuipc;
            OP_SYSTEM: opclass = ClsSystem;
            default:   opclass = ClsIllegal;
        endcase
    end

    assign illegal = (opclass == ClsIllegal);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// handshakes with the memory port under a watchdog, and counts retired instructions.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             alu_a_sel,
    output logic [1:0]       alu_b_sel,
    output logic [1:0]       alu_op,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state_o
);

    localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t           state_q, state_d;
    opclass_t         cls_q, cls_d, dec_cls;
    logic             dec_illegal;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             mem_wait, wd_expire, retire;

    rv_opcode_class u_opcode_class (
        .opcode  (opcode),
        .opclass (dec_cls),
        .illegal (dec_illegal)
    );

    // Only FETCH and MEM hold a request, so waiting is decoded from state directly.
    assign mem_wait  = ((state_q == StFetch) || (state_q == StMem)) && !mem_ready;
    assign wd_expire = (TIMEOUT != 0) && mem_wait && ((32'(wd_q) + 32'd1) == TIMEOUT);

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        fault_d = fault_q;
        unique case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: if (mem_ready) state_d = StDecode;
            StDecode: begin
                if (dec_cls == ClsSystem) begin
                    state_d = StHalt;
                end else if (dec_illegal) begin
                    state_d = StHalt;
                    fault_d = 1'b1;
                end else begin
                    state_d = StExec;
                    cls_d   = dec_cls;
                end
            end
            StExec: begin
                case (cls_q)
                    ClsLoad, ClsStore: state_d = StMem;
                    ClsBranch:         state_d = StFetch;
                    default:           state_d = StWb;
                endcase
            end
            StMem:   if (mem_ready) state_d = (cls_q == ClsStore) ? StFetch : StWb;
            StWb:    state_d = StFetch;
            default: state_d = state_q;
        endcase
        if (wd_expire) begin
            state_d = StHalt;
            fault_d = 1'b1;
        end
    end

    assign retire = (state_d == StFetch) &&
                    ((state_q == StExec) || (state_q == StMem) || (state_q == StWb));

    always_comb begin
        instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
        wd_d      = (state_d != state_q || !mem_wait) ? '0 : wd_q + WD_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cls_q     <= ClsRtype;
            fault_q   <= 1'b0;
            instret_q <= '0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            fault_q   <= fault_d;
            instret_q <= instret_d;
            wd_q      <= wd_d;
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_HOLD;
        reg_write = 1'b0;
        wb_sel    = WB_ALU;
        alu_a_sel = 1'b0;
        alu_b_sel = ALUB_RS2;
        alu_op    = ALU_ADD;
        halted    = 1'b0;
        unique case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_PLUS4;
                end
            end
            StDecode: begin
                // Branch target is precomputed here as PC + imm.
                alu_a_sel = 1'b1;
                alu_b_sel = ALUB_IMM;
            end
            StExec: begin
                case (cls_q)
                    ClsRtype: alu_op = ALU_FUNCT;
                    ClsIalu: begin
                        alu_b_sel = ALUB_IMM;
                        alu_op    = ALU_FUNCT;
                    end
                    ClsBranch: begin
                        alu_op   = ALU_CMP;
                        pc_src   = PC_TARGET;
                        pc_write = branch_taken;
                    end
                    ClsAuipc, ClsJal: begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = ALUB_IMM;
                    end
                    default: alu_b_sel = ALUB_IMM;
                endcase
            end
            StMem: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (cls_q == ClsStore);
            end
            StWb: begin
                reg_write = 1'b1;
                if (cls_q == ClsLoad) begin
                    wb_sel = WB_MEM;
                end else if ((cls_q == ClsJal) || (cls_q == ClsJalr)) begin
                    wb_sel   = WB_PC4;
                    pc_write = 1'b1;
                    pc_src   = PC_TARGET;
                end
            end
            StHalt:  halted = 1'b1;
            default: ;
        endcase
    end

    assign fault   = fault_q;
    assign instret = instret_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into its
// expected per-cycle output trace, then driven and compared cycle by cycle.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

    localparam int unsigned TMO = 4;
    localparam logic [6:0] LEGAL_OPS [9] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                            7'b0100011, 7'b1100011, 7'b1101111,
                                            7'b1100111, 7'b0110111, 7'b0010111};
    localparam logic [6:0] SYS_OP = 7'b1110011;

    typedef struct packed {
        logic [2:0] state;
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       alu_a_sel;
        logic [1:0] alu_b_sel;
        logic [1:0] alu_op;
        logic       halted;
    } outs_t;

    typedef struct packed {
        outs_t      o;
        logic [6:0] op;
        logic       ready;
        logic       taken;
        logic       fault;
        logic       retire;
    } cyc_t;

    logic        clk = 1'b1;
    logic        rst = 1'b0;
    logic [6:0]  opcode;
    logic        branch_taken, mem_ready;
    logic        mem_req, mem_we, addr_sel, ir_write, pc_write, reg_write, alu_a_sel;
    logic        halted, fault;
    logic [1:0]  pc_src, wb_sel, alu_b_sel, alu_op;
    logic [31:0] instret;
    logic [2:0]  state_o;

    cyc_t        plan[$];
    logic        plan_halts;
    logic [31:0] instret_m;
    int          n_checks, n_errors;

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .CNT_W   (32),
        .TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .addr_sel     (addr_sel),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .reg_write    (reg_write),
        .wb_sel       (wb_sel),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .alu_op       (alu_op),
        .halted       (halted),
        .fault        (fault),
        .instret      (instret),
        .state_o      (state_o)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic outs_t observed();
        return {state_o, mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, reg_write,
                wb_sel, alu_a_sel, alu_b_sel, alu_op, halted};
    endfunction

    // Baseline cycle: everything inactive, PC held; inputs that must be ignored are random.
    function automatic cyc_t mk(input logic [2:0] st, input logic [6:0] op);
        cyc_t c;
        c = '0;
        c.o.state  = st;
        c.o.pc_src = 2'd2;
        c.op       = op;
        c.ready    = 1'($urandom_range(0, 1));
        c.taken    = 1'($urandom_range(0, 1));
        return c;
    endfunction

    function automatic logic known_op(input logic [6:0] o);
        if (o == SYS_OP) return 1'b1;
        for (int k = 0; k < 9; k++) if (LEGAL_OPS[k] == o) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [6:0] illegal_op();
        logic [6:0] o;
        for (int k = 0; k < 16; k++) begin
            o = 7'($urandom);
            if (!known_op(o)) return o;
        end
        return 7'h00;
    endfunction

    task automatic add_halt(input logic f);
        cyc_t c;
        for (int k = 0; k < 2; k++) begin
            c = mk(3'd6, 7'($urandom));
            c.o.halted = 1'b1;
            c.fault    = f;
            plan.push_back(c);
        end
        plan_halts = 1'b1;
    endtask

    task automatic add_wb(input logic [1:0] sel);
        cyc_t c;
        c = mk(3'd5, 7'($urandom));
        c.o.reg_write = 1'b1;
        c.o.wb_sel    = sel;
        if (sel == 2'd2) begin
            c.o.pc_write = 1'b1;
            c.o.pc_src   = 2'd1;
        end
        c.retire = 1'b1;
        plan.push_back(c);
    endtask

    // fw/mw: wait cycles before mem_ready in FETCH/MEM; TMO or more trips the watchdog.
    task automatic plan_instr(input logic [6:0] op, input logic taken, input int fw, input int mw);
        cyc_t c;
        logic is_st;
        plan.delete();
        plan_halts = 1'b0;
        is_st = (op == 7'b0100011);
        for (int i = 0; i < fw && i < int'(TMO); i++) begin
            c = mk(3'd1, op);
            c.o.mem_req = 1'b1;
            c.ready     = 1'b0;
            plan.push_back(c);
        end
        if (fw >= int'(TMO)) begin
            add_halt(1'b1);
            return;
        end
        c = mk(3'd1, op);
        c.o.mem_req  = 1'b1;
        c.o.ir_write = 1'b1;
        c.o.pc_write = 1'b1;
        c.o.pc_src   = 2'd0;
        c.ready      = 1'b1;
        plan.push_back(c);
        c = mk(3'd2, op);
        c.o.alu_a_sel = 1'b1;
        c.o.alu_b_sel = 2'd1;
        plan.push_back(c);
        if (op == SYS_OP) begin
            add_halt(1'b0);
            return;
        end
        if (!known_op(op)) begin
            add_halt(1'b1);
            return;
        end
        // From EXEC on, the opcode bus may change: the class must already be latched.
        c = mk(3'd3, 7'($urandom));
        case (op)
            7'b0110011: begin c.o.alu_op = 2'd2; plan.push_back(c); add_wb(2'd0); end
            7'b0010011: begin
                c.o.alu_b_sel = 2'd1; c.o.alu_op = 2'd2; plan.push_back(c); add_wb(2'd0);
            end
            7'b0110111: begin c.o.alu_b_sel = 2'd1; plan.push_back(c); add_wb(2'd0); end
            7'b0010111: begin
                c.o.alu_a_sel = 1'b1; c.o.alu_b_sel = 2'd1; plan.push_back(c); add_wb(2'd0);
            end
            7'b1101111: begin
                c.o.alu_a_sel = 1'b1; c.o.alu_b_sel = 2'd1; plan.push_back(c); add_wb(2'd2);
            end
            7'b1100111: begin c.o.alu_b_sel = 2'd1; plan.push_back(c); add_wb(2'd2); end
            7'b1100011: begin
                c.o.alu_op   = 2'd1;
                c.o.pc_src   = 2'd1;
                c.o.pc_write = taken;
                c.taken      = taken;
                c.retire     = 1'b1;
                plan.push_back(c);
            end
            default: begin
                c.o.alu_b_sel = 2'd1;
                plan.push_back(c);
                for (int i = 0; i < mw && i < int'(TMO); i++) begin
                    c = mk(3'd4, 7'($urandom));
                    c.o.mem_req = 1'b1; c.o.addr_sel = 1'b1; c.o.mem_we = is_st;
                    c.ready = 1'b0;
                    plan.push_back(c);
                end
                if (mw >= int'(TMO)) begin
                    add_halt(1'b1);
                    return;
                end
                c = mk(3'd4, 7'($urandom));
                c.o.mem_req = 1'b1; c.o.addr_sel = 1'b1; c.o.mem_we = is_st;
                c.ready  = 1'b1;
                c.retire = is_st;
                plan.push_back(c);
                if (!is_st) add_wb(2'd1);
            end
        endcase
    endtask

    task automatic exec_plan(input int stop);
        for (int i = 0; i < plan.size(); i++) begin
            if (stop >= 0 && i >= stop) break;
            @(negedge clk);
            opcode       = plan[i].op;
            mem_ready    = plan[i].ready;
            branch_taken = plan[i].taken;
            #1;
            check_val($sformatf("op%b_cyc%0d_st%0d_outs", plan[0].op, i, plan[i].o.state),
                      32'(observed()), 32'(plan[i].o));
            check_val($sformatf("op%b_cyc%0d_instret", plan[0].op, i), instret, instret_m);
            check_val($sformatf("op%b_cyc%0d_fault", plan[0].op, i), 32'(fault),
                      32'(plan[i].fault));
            @(posedge clk);
            if (plan[i].retire) instret_m = instret_m + 32'd1;
        end
    endtask

    // Called just after a rising edge: reset pulses between edges, then one IDLE cycle.
    task automatic do_reset();
        cyc_t idle;
        idle = mk(3'd0, 7'($urandom));
        #2 rst = 1'b1;
        #1;
        check_val("rst_outs", 32'(observed()), 32'(idle.o));
        check_val("rst_instret", instret, 32'd0);
        check_val("rst_fault", 32'(fault), 32'd0);
        #1 rst = 1'b0;
        instret_m = 32'd0;
        plan.delete();
        plan.push_back(idle);
        exec_plan(-1);
    endtask

    task automatic run(input logic [6:0] op, input logic taken, input int fw, input int mw);
        plan_instr(op, taken, fw, mw);
        exec_plan(-1);
        if (plan_halts) do_reset();
    endtask

    initial begin
        int         r, fw, mw;
        logic [6:0] op;
        n_checks     = 0;
        n_errors     = 0;
        instret_m    = 32'd0;
        opcode       = 7'd0;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;

        do_reset();
        run(7'b0010011, 1'b0, 0, 0);  // addi
        run(7'b0000011, 1'b0, 0, 3);  // load with three wait states
        run(7'b1100011, 1'b1, 0, 0);  // branch taken
        run(7'b1100011, 1'b0, 1, 0);  // branch not taken
        run(7'b0100011, 1'b0, 2, 1);  // store
        run(7'b1101111, 1'b0, 0, 0);  // jal
        run(7'b0000000, 1'b0, 0, 0);  // illegal
        run(7'b0010011, 1'b0, 0, 0);
        run(SYS_OP, 1'b0, 0, 0);      // system halt
        run(7'b0010011, 1'b0, 4, 0);  // fetch timeout
        run(7'b0010011, 1'b0, 0, 0);
        run(7'b0000011, 1'b0, 0, 4);  // mem timeout

        // Async reset in the middle of a store handshake.
        run(7'b0110011, 1'b0, 0, 0);
        plan_instr(7'b0100011, 1'b0, 0, 2);
        exec_plan(4);
        do_reset();

        for (int n = 0; n < 80; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 5) op = SYS_OP;
            else if (r < 10) op = illegal_op();
            else op = LEGAL_OPS[$urandom_range(0, 8)];
            fw = ($urandom_range(0, 99) < 3) ? 4 : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 99) < 3) ? 4 : int'($urandom_range(0, 3));
            run(op, 1'($urandom_range(0, 1)), fw, mw);
        end

        @(negedge clk);
        #1;
        check_val("final_instret", instret, instret_m);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
